// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array controller.
package sa_pkg;

   localparam int unsigned SA_LEN_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR_AB,
      ST_CLR_MAC,
      ST_FEED,
      ST_DRAIN,
      ST_OUT,
      ST_OUT_CLR,
      ST_DONE
   } sa_state_e;

   // First non-empty segment following cur; zero-length segments are skipped entirely.
   function automatic sa_state_e next_seg(input sa_state_e cur,
                                          input logic      feed_nz,
                                          input logic      drain_nz,
                                          input logic      out_nz);
      sa_state_e nxt;
      nxt = ST_OUT_CLR;
      if (cur == ST_CLR_MAC && feed_nz)
         nxt = ST_FEED;
      else if ((cur == ST_CLR_MAC || cur == ST_FEED) && drain_nz)
         nxt = ST_DRAIN;
      else if ((cur inside {ST_CLR_MAC, ST_FEED, ST_DRAIN}) && out_nz)
         nxt = ST_OUT;
      return nxt;
   endfunction

endpackage

// File: rtl/sa_len_cnt.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module sa_len_cnt
   import sa_pkg::*;
#(
   parameter int unsigned LEN_W = SA_LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [LEN_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic [LEN_W-1:0] o_cnt,
   output logic             o_zero
);

   logic [LEN_W-1:0] r_cnt;

   // Load has priority over decrement; decrement stops at zero.
   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && r_cnt != '0)
         r_cnt <= r_cnt - LEN_W'(1);
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sa_ctrl.sv
// Systolic-array job sequencer: clear, feed, drain, read out, clear, done.
// Optional busy-cycle counter on port perf_cycles when SA_CTRL_PERF_EN is defined.
module sa_ctrl
   import sa_pkg::*;
#(
   parameter int unsigned ROW_NUM = 32,
   parameter int unsigned COL_NUM = 32,
   parameter int unsigned LEN_W   = SA_LEN_W
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SA_CTRL_PERF_EN
   output logic [31:0]      perf_cycles,
`endif
   input  logic             start,
   input  logic             cfg_mode,
   input  logic [LEN_W-1:0] cfg_feed_len,
   input  logic [LEN_W-1:0] cfg_drain_len,
   input  logic [LEN_W-1:0] cfg_out_len,
   output logic             busy,
   output logic             done,
   output logic             sa_reset,
   output logic             sa_en,
   output logic             sa_mode,
   output logic             sa_channel_out_reset,
   output logic             sa_channel_out_en,
   output logic             feed_valid,
   output logic [LEN_W-1:0] feed_idx
);

   // Degenerate array geometry is rejected at elaboration.
   if (ROW_NUM < 1 || COL_NUM < 1) begin : g_bad_dims
      $error("sa_ctrl: ROW_NUM and COL_NUM must be nonzero");
   end

   sa_state_e        r_state;
   logic             r_mode;
   logic [LEN_W-1:0] r_feed_len;
   logic [LEN_W-1:0] r_drain_len;
   logic [LEN_W-1:0] r_out_len;

   sa_state_e        w_seg;
   logic             w_adv;
   logic             w_dec;
   logic [LEN_W-1:0] w_load_val;
   logic [LEN_W-1:0] w_cnt;
   logic             w_zero;

   assign w_seg = next_seg(r_state, |r_feed_len, |r_drain_len, |r_out_len);
   assign w_dec = (r_state inside {ST_FEED, ST_DRAIN, ST_OUT});
   assign w_adv = (r_state == ST_CLR_MAC) || (w_dec && w_zero);

   // Counter preload for the segment about to be entered.
   always_comb begin
      w_load_val = '0;
      case (w_seg)
         ST_FEED:  w_load_val = r_feed_len  - LEN_W'(1);
         ST_DRAIN: w_load_val = r_drain_len - LEN_W'(1);
         ST_OUT:   w_load_val = r_out_len   - LEN_W'(1);
         default:  w_load_val = '0;
      endcase
   end

   sa_len_cnt #(.LEN_W(LEN_W)) u_len_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_adv),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_zero)
   );

   // Job state machine; configuration is captured only when a job is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_mode      <= 1'b0;
         r_feed_len  <= '0;
         r_drain_len <= '0;
         r_out_len   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode      <= cfg_mode;
                  r_feed_len  <= cfg_feed_len;
                  r_drain_len <= cfg_drain_len;
                  r_out_len   <= cfg_out_len;
                  r_state     <= ST_CLR_AB;
               end
            end
            ST_CLR_AB:  r_state <= ST_CLR_MAC;
            ST_CLR_MAC: r_state <= w_seg;
            ST_FEED:    if (w_zero) r_state <= w_seg;
            ST_DRAIN:   if (w_zero) r_state <= w_seg;
            ST_OUT:     if (w_zero) r_state <= ST_OUT_CLR;
            ST_OUT_CLR: r_state <= ST_DONE;
            ST_DONE:    r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   // Moore decode of the state register and segment counter.
   assign busy                 = (r_state != ST_IDLE);
   assign done                 = (r_state == ST_DONE);
   assign sa_reset             = (r_state == ST_CLR_AB) || (r_state == ST_CLR_MAC);
   assign sa_en                = (r_state == ST_FEED) || (r_state == ST_DRAIN);
   assign sa_mode              = r_mode;
   assign sa_channel_out_reset = (r_state == ST_CLR_AB) || (r_state == ST_OUT_CLR);
   assign sa_channel_out_en    = (r_state == ST_OUT);
   assign feed_valid           = (r_state == ST_FEED);
   assign feed_idx             = feed_valid ? LEN_W'(r_feed_len - LEN_W'(1) - w_cnt) : '0;

`ifdef SA_CTRL_PERF_EN
   logic [31:0] r_perf;

   // Busy-cycle counter; saturates and is cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         r_perf <= '0;
      else if (busy && r_perf != '1)
         r_perf <= r_perf + 32'(1);
   end

   assign perf_cycles = r_perf;
`endif

endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 SHALL have parameter ROW_NUM, default 32, meaning the physical row count of the systolic array.
REQ-002 SHALL have parameter COL_NUM, default 32, meaning the physical column count.
REQ-003 SHALL have parameter LEN_W, default 6, meaning the width of every length field and of feed_idx.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  job request; sampled only in IDLE.
REQ-007 cfg_mode  input  1  0 = 8x8 mode, 1 = 1x8 mode; latched at start.
REQ-008 cfg_feed_len  input  LEN_W  number of FEED cycles; latched at start.
REQ-009 cfg_drain_len  input  LEN_W  number of DRAIN cycles; latched at start.
REQ-010 cfg_out_len  input  LEN_W  number of OUT cycles (output channels); latched at start.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse in DONE.
REQ-013 sa_reset / sa_en / sa_mode / sa_channel_out_reset / sa_channel_out_en  output  1 each  array control.
REQ-014 feed_valid  output  1  high while row/column operands must be driven.
REQ-015 feed_idx  output  LEN_W  index of the operand slice to drive; 0 when feed_valid is low.

Function
REQ-016 SHALL be a Moore FSM with states IDLE, CLR_AB, CLR_MAC, FEED, DRAIN, OUT, OUT_CLR, DONE; all outputs decode from the state register plus one down-counter.
REQ-017 IDLE: start=1 -> CLR_AB next cycle and latch cfg_*; start ignored in all other states.
REQ-018 CLR_AB: sa_reset=1, sa_channel_out_reset=1, one cycle -> CLR_MAC.
REQ-019 CLR_MAC: sa_reset=1, one cycle -> FEED; a zero cfg_feed_len skips FEED and goes to DRAIN.
REQ-020 FEED: sa_en=1, feed_valid=1, feed_idx counts 0..cfg_feed_len-1, one per cycle -> DRAIN after the last index.
REQ-021 DRAIN: sa_en=1, feed_valid=0, cfg_drain_len cycles -> OUT; zero length skips directly to OUT.
REQ-022 OUT: sa_en=0, sa_channel_out_en=1 for cfg_out_len cycles -> OUT_CLR; zero length skips to OUT_CLR.
REQ-023 OUT_CLR: sa_channel_out_reset=1, one cycle -> DONE.
REQ-024 DONE: done=1, one cycle -> IDLE; start in DONE is ignored.
REQ-025 sa_mode SHALL equal the latched cfg_mode from CLR_AB through DONE, and hold its last value in IDLE.
REQ-026 Length counters SHALL be LEN_W wide, load length-1 on state entry, decrement to 0, never wrap.
REQ-027 Total job latency SHALL be 5 + feed + drain + out cycles from the start cycle to the done pulse, inclusive of CLR_AB, CLR_MAC, OUT_CLR and DONE.
REQ-028 sa_en and sa_channel_out_en SHALL never be high in the same cycle.

Reset
REQ-029 reset=1 SHALL force state IDLE from any state, including mid-job, on the next edge.
REQ-030 Reset values: busy=0, done=0, sa_reset=0, sa_en=0, sa_mode=0, sa_channel_out_reset=0, sa_channel_out_en=0, feed_valid=0, feed_idx=0, latched cfg=0.

Configuration
REQ-031 SA_CTRL_PERF_EN defined: add output perf_cycles [31:0], which counts busy cycles, saturates at all-ones, clears on reset, and never clears on start.
REQ-032 SA_CTRL_PERF_EN undefined: no perf_cycles port and no counter logic; all other behaviour is identical.

Structure
REQ-033 Shared package sa_pkg SHALL hold the state enum type and the LEN_W default constant.
REQ-034 The single sub-module sa_len_cnt SHALL implement the loadable, saturating down-counter with a zero flag.

Verification
REQ-035 mode=0, feed=2, drain=2, out=2, start pulse: CLR_AB 1 cycle, CLR_MAC 1, sa_en 4 cycles with feed_idx 0,1, channel_out_en 2 cycles, done 11 cycles after start, sa_mode=0 throughout.
REQ-036 mode=1, feed=2, drain=1, out=2: sa_mode=1 from CLR_AB to DONE, done after 10 cycles, busy deasserts the cycle after done.
REQ-037 feed=0, drain=0, out=1: sequence CLR_AB, CLR_MAC, OUT, OUT_CLR, DONE; feed_valid is never high.
REQ-038 reset asserted during FEED at feed_idx=1: next cycle IDLE, all outputs at reset values; a new start then runs a full job normally.
REQ-039 start held high continuously with feed=1, drain=1, out=1: back-to-back jobs, each done pulse exactly one cycle, and cfg changes mid-job have no effect until the next start.
